// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: branch funct3 codes, redirect FSM states and the branch condition helper shared with decode
package riscv_ctrl_pkg;
  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;
  typedef enum logic {RUN, PEND} state_t;
  function automatic logic br_cond(input logic [2:0] f3, input logic cf, input logic zf, input logic sf);
    return f3 == BR_BEQ  ? zf  :
           f3 == BR_BNE  ? !zf :
           f3 == BR_BLT  ? sf  :
           f3 == BR_BGE  ? !sf :
           f3 == BR_BLTU ? !cf :
           f3 == BR_BGEU ? cf  : 1'b0;
  endfunction
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags a load in EX whose nonzero rd feeds an ID source (ports: ex_valid, ex_mem_read, ex_rd, id_rs1, id_rs2 in; lu out)
module load_use_detect (
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  output logic       lu
);
  assign lu = ex_valid && ex_mem_read && ex_rd != 5'd0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
endmodule

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: EX-stage redirect/load-use control; inputs ex_* branch info, id_rs*, imem_ready; outputs pc_sel/pc_target/pc_stall, IF/ID and ID/EX flush/stall, redir_pending, stat_* counters when BRANCH_STATS_EN is defined
module branch_redirect_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic            ex_jump,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_cf,
  input  logic            ex_zf,
  input  logic            ex_sf,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_mem_read,
  input  logic [4:0]      ex_rd,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic            imem_ready,
  output logic            pc_sel,
  output logic [XLEN-1:0] pc_target,
  output logic            pc_stall,
  output logic            if_id_stall,
  output logic            if_id_flush,
  output logic            id_ex_flush,
`ifdef BRANCH_STATS_EN
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_taken,
  output logic [CNT_W-1:0] stat_stalls,
`endif
  output logic            redir_pending
);
  state_t            r_state, w_next;
  logic [XLEN-1:0]   r_redir_q;
  logic              w_take, w_lu, w_run;
  assign w_take = ex_valid && (ex_jump || (ex_branch && br_cond(ex_funct3, ex_cf, ex_zf, ex_sf)));
  assign w_run  = r_state == RUN;
  load_use_detect u_lu (
    .ex_valid   (ex_valid),
    .ex_mem_read(ex_mem_read),
    .ex_rd      (ex_rd),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .lu         (w_lu)
  );
  always_comb begin
    w_next      = r_state;
    pc_sel      = 1'b0;
    pc_target   = ex_target;
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (!w_run) begin
      pc_target   = r_redir_q;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      pc_sel      = imem_ready;
      w_next      = imem_ready ? RUN : PEND;
    end else if (w_take) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      pc_sel      = imem_ready;
      w_next      = imem_ready ? RUN : PEND;
    end else if (w_lu) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end
  end
  assign redir_pending = !w_run;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RUN;
      r_redir_q <= '0;
    end else begin
      r_state <= w_next;
      if (w_run && w_take && !imem_ready) r_redir_q <= ex_target;
    end
  end
`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] r_br, r_tk, r_st;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br <= '0;
      r_tk <= '0;
      r_st <= '0;
    end else begin
      if (w_run && ex_valid && ex_branch && !(&r_br)) r_br <= r_br + 1'b1;
      if (w_run && w_take && !(&r_tk)) r_tk <= r_tk + 1'b1;
      if (w_run && !w_take && w_lu && !(&r_st)) r_st <= r_st + 1'b1;
    end
  end
  assign stat_branches = r_br;
  assign stat_taken    = r_tk;
  assign stat_stalls   = r_st;
`endif
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: directed and random checks of branch_redirect_ctrl against a behavioural model
module tb_branch_redirect_ctrl;
  localparam int XLEN = 32;
  localparam int CW   = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic ex_valid, ex_branch, ex_jump, ex_cf, ex_zf, ex_sf, ex_mem_read, imem_ready;
  logic [2:0] ex_funct3;
  logic [XLEN-1:0] ex_target;
  logic [4:0] ex_rd, id_rs1, id_rs2;
  logic pc_sel, pc_stall, if_id_stall, if_id_flush, id_ex_flush, redir_pending;
  logic [XLEN-1:0] pc_target;
`ifdef BRANCH_STATS_EN
  logic [CW-1:0] stat_branches, stat_taken, stat_stalls;
`endif
  int total = 0, bad = 0;
  bit m_pend = 0;
  logic [XLEN-1:0] m_tgt = '0;
  logic [CW-1:0] m_br = '0, m_tk = '0, m_st = '0;

  branch_redirect_ctrl #(.XLEN(XLEN), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_funct3(ex_funct3), .ex_cf(ex_cf), .ex_zf(ex_zf), .ex_sf(ex_sf), .ex_target(ex_target),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .imem_ready(imem_ready), .pc_sel(pc_sel), .pc_target(pc_target), .pc_stall(pc_stall),
    .if_id_stall(if_id_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
`ifdef BRANCH_STATS_EN
    .stat_branches(stat_branches), .stat_taken(stat_taken), .stat_stalls(stat_stalls),
`endif
    .redir_pending(redir_pending)
  );

  always #5 clk = ~clk;

  function automatic bit cond_of(input logic [2:0] f, input logic cf, input logic zf, input logic sf);
    bit eq = zf, lt_s = sf, lt_u = !cf;
    case (f)
      3'b000: return eq;
      3'b001: return !eq;
      3'b100: return lt_s;
      3'b101: return !lt_s;
      3'b110: return lt_u;
      3'b111: return !lt_u;
      default: return 0;
    endcase
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == {CW{1'b1}}) ? c : c + 1'b1;
  endfunction

  task automatic check(input string tag, input logic [XLEN+5:0] exp);
    logic [XLEN+5:0] obs;
    obs = {pc_sel, pc_target, pc_stall, if_id_stall, if_id_flush, id_ex_flush, redir_pending};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
`ifdef BRANCH_STATS_EN
    total++;
    assert ({stat_branches, stat_taken, stat_stalls} === {m_br, m_tk, m_st}) else begin
      bad++;
      $error("FAIL %s_stats observed=%h expected=%h", tag, {stat_branches, stat_taken, stat_stalls}, {m_br, m_tk, m_st});
    end
`endif
  endtask

  task automatic set_in(input logic v, input logic br, input logic j, input logic [2:0] f3,
                        input logic cf, input logic zf, input logic sf, input logic [XLEN-1:0] tg,
                        input logic mr, input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                        input logic rdy);
    ex_valid = v; ex_branch = br; ex_jump = j; ex_funct3 = f3; ex_cf = cf; ex_zf = zf; ex_sf = sf;
    ex_target = tg; ex_mem_read = mr; ex_rd = rd; id_rs1 = r1; id_rs2 = r2; imem_ready = rdy;
  endtask

  task automatic step(input string tag);
    bit take, lu, sel, stall, fl_if, fl_ex;
    logic [XLEN-1:0] tgt;
    #1;
    take = ex_valid && (ex_jump || (ex_branch && cond_of(ex_funct3, ex_cf, ex_zf, ex_sf)));
    lu = ex_valid && ex_mem_read && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
    sel = 0; stall = 0; fl_if = 0; fl_ex = 0; tgt = ex_target;
    if (m_pend) begin
      tgt = m_tgt; fl_if = 1; fl_ex = 1; sel = imem_ready;
    end else if (take) begin
      fl_if = 1; fl_ex = 1; sel = imem_ready;
    end else if (lu) begin
      stall = 1; fl_ex = 1;
    end
    check(tag, {sel, tgt, stall, stall, fl_if, fl_ex, m_pend});
    if (!m_pend) begin
      if (ex_valid && ex_branch) m_br = sat_inc(m_br);
      if (take) m_tk = sat_inc(m_tk);
      if (!take && lu) m_st = sat_inc(m_st);
      if (take && !imem_ready) begin m_pend = 1; m_tgt = ex_target; end
    end else if (imem_ready) m_pend = 0;
    @(negedge clk);
  endtask

  initial begin
    set_in(0,0,0,0,0,0,0,0,0,0,0,0,0);
    #2;
    check("reset_idle", '0);
    @(negedge clk); rst_n = 1'b1;
    set_in(1,1,0,3'b000,0,1,0,32'h100,0,0,0,0,1); step("beq_taken");
    set_in(1,1,0,3'b110,1,0,0,32'h200,0,0,0,0,1); step("bltu_nt");
    set_in(1,1,0,3'b111,1,0,0,32'h300,0,0,0,0,1); step("bgeu_taken");
    set_in(1,1,0,3'b010,0,1,1,32'h400,0,0,0,0,1); step("f3_010");
    set_in(1,1,0,3'b011,1,1,1,32'h440,0,0,0,0,1); step("f3_011");
    set_in(1,0,1,3'b000,0,0,0,32'h2000,0,0,0,0,0); step("jal_notready");
    set_in(0,0,0,0,0,0,0,32'h55,0,0,0,0,0); step("pend1");
    step("pend2");
    set_in(1,0,1,0,0,0,0,32'h77,0,0,0,0,0); step("pend3_ignore");
    set_in(0,0,0,0,0,0,0,32'h55,0,0,0,0,1); step("pend_release");
    set_in(1,0,0,0,0,0,0,32'h10,1,5,1,5,1); step("lu_rs2");
    set_in(1,0,0,0,0,0,0,32'h10,1,0,0,0,1); step("lu_x0");
    set_in(1,1,0,3'b000,0,1,0,32'h500,1,5,5,0,1); step("take_over_lu");
    set_in(1,0,0,0,0,0,0,32'h10,1,7,7,3,1); step("lu_rs1");
    set_in(1,0,1,0,0,0,0,32'h900,0,0,0,0,0); step("jal_to_pend");
    set_in(0,0,0,0,0,0,0,0,0,0,0,0,0);
    #2 rst_n = 1'b0;
    m_pend = 0; m_br = '0; m_tk = '0; m_st = '0;
    #1 check("async_reset_pend", '0);
    @(negedge clk); rst_n = 1'b1;
    set_in(0,0,0,0,0,0,0,0,0,0,0,0,1); step("post_reset_rdy");
    for (int i = 0; i < 20; i++) begin
      set_in(1,1,0,3'b000,0,1,0,32'h1000 + i,0,0,0,0,1); step("taken_sat");
    end
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0,3) != 0, $urandom_range(0,1), $urandom_range(0,7) == 0, 3'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom_range(0,1),
             5'($urandom_range(0,3)), 5'($urandom_range(0,3)), 5'($urandom_range(0,3)),
             $urandom_range(0,3) != 0);
      step("random");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
